fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/decode/execute sequencer with branch and halt handling
// Define FETCH_TIMEOUT_EN to trap a fetch that waits 16 un-acked cycles into a sticky ERROR state.
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [11:0] pc_in,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        zero_flag,
    output logic        exec_start,
    input  logic        exec_done,
    output logic        PC_Write,
    output logic        PC_Src,
    output logic [11:0] PC_offset,
    output logic [15:0] instr_out,
    output logic [15:0] retired,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXEC_WAIT,
        S_UPDATE,
`ifdef FETCH_TIMEOUT_EN
        S_HALT,
        S_ERROR
`else
        S_HALT
`endif
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] OP_JUMP  = 4'hD;
    localparam logic [3:0] OP_BZERO = 4'hC;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        take_q, take_d;
    logic [15:0] retired_q, retired_d;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  wait_q, wait_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            take_q    <= 1'b0;
            retired_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            take_q    <= take_d;
            retired_q <= retired_d;
`ifdef FETCH_TIMEOUT_EN
            wait_q    <= wait_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        take_d     = take_q;
        retired_d  = retired_q;
`ifdef FETCH_TIMEOUT_EN
        wait_d     = wait_q;
`endif
        imem_req   = 1'b0;
        imem_addr  = '0;
        exec_start = 1'b0;
        PC_Write   = 1'b0;
        PC_Src     = 1'b0;
        PC_offset  = '0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    // wait_q counts prior misses, so 15 here means this is the 16th
                    if (wait_q == 4'hF) begin
                        state_d = S_ERROR;
                    end
                    wait_d = 4'(wait_q + 4'd1);
`endif
                end
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    OP_JUMP: begin
                        take_d  = 1'b1;
                        state_d = S_UPDATE;
                    end
                    OP_BZERO: begin
                        take_d  = zero_flag;
                        state_d = S_UPDATE;
                    end
                    default: begin
                        take_d  = 1'b0;
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                exec_start = 1'b1;
                state_d    = S_EXEC_WAIT;
            end
            S_EXEC_WAIT: begin
                if (exec_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                PC_Write  = 1'b1;
                PC_Src    = take_q;
                PC_offset = ir_q[11:0];
                retired_d = retired_q + 16'd1;
                // run is only honoured here so an instruction is never cut short
                if (run) begin
                    state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERROR: begin
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr_out = ir_q;
    assign retired   = retired_q;

`ifdef FETCH_TIMEOUT_EN
    assign fault = (state_q == S_ERROR);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Instruction-level model checked every cycle, plus directed literal checks per scenario.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        zero_flag = 1'b0;
    logic        ack_en = 1'b1;
    logic [11:0] pc_in = '0;
    logic [15:0] imem_rdata = '0;
    logic [7:0]  done_delay = 8'd2;
    logic [7:0]  done_cnt = '0;

    logic        imem_req, imem_ack, exec_start, exec_done;
    logic        PC_Write, PC_Src, halted, fault;
    logic [11:0] imem_addr, PC_offset;
    logic [15:0] instr_out, retired;

    assign imem_ack  = imem_req & ack_en;
    assign exec_done = (done_cnt == done_delay);

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .zero_flag  (zero_flag),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .PC_Write   (PC_Write),
        .PC_Src     (PC_Src),
        .PC_offset  (PC_offset),
        .instr_out  (instr_out),
        .retired    (retired),
        .halted     (halted),
        .fault      (fault)
    );

    // datapath stand-in: exec_done fires done_delay cycles after exec_start
    always @(posedge clk) begin
        if (exec_start) done_cnt <= 8'd1;
        else if (done_cnt != 8'd0 && done_cnt < 8'd200) done_cnt <= done_cnt + 8'd1;
    end

    // instruction-level model: mode plus age of the current instruction since its fetch ack
    localparam int M_IDLE = 0, M_FETCH = 1, M_BUSY = 2, M_HALT = 3, M_ERROR = 4;
    int          m_mode = M_IDLE;
    int          m_age = 0;
    int          m_wait = 0;
    bit          m_valid = 1'b0;
    bit          m_upd = 1'b0;
    bit          m_take = 1'b0;
    logic [15:0] m_ir = '0;
    logic [15:0] m_ret = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_mode  <= M_IDLE;
            m_ir    <= '0;
            m_ret   <= '0;
            m_upd   <= 1'b0;
            m_take  <= 1'b0;
            m_wait  <= 0;
        end else begin
            case (m_mode)
                M_IDLE: if (run) begin
                    m_mode <= M_FETCH;
                    m_wait <= 0;
                end
                M_FETCH: begin
                    if (ack_en) begin
                        m_ir   <= imem_rdata;
                        m_mode <= M_BUSY;
                        m_age  <= 1;
                        m_upd  <= 1'b0;
                    end else begin
                        m_wait <= m_wait + 1;
`ifdef FETCH_TIMEOUT_EN
                        if (m_wait + 1 == 16) m_mode <= M_ERROR;
`endif
                    end
                end
                M_BUSY: begin
                    if (m_upd) begin
                        m_ret  <= m_ret + 16'd1;
                        m_upd  <= 1'b0;
                        m_mode <= run ? M_FETCH : M_IDLE;
                        m_wait <= 0;
                    end else begin
                        m_age <= m_age + 1;
                        if (m_age == 1) begin
                            case (m_ir[15:12])
                                4'hF: m_mode <= M_HALT;
                                4'hD: begin m_take <= 1'b1; m_upd <= 1'b1; end
                                4'hC: begin m_take <= zero_flag; m_upd <= 1'b1; end
                                default: m_take <= 1'b0;
                            endcase
                        end else if (m_age >= 3 && exec_done) begin
                            m_upd <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pcw_cnt = 0, es_cnt = 0, req_cnt = 0, ack_cnt = 0;
    int          ack_cyc = 0, upd_cyc = 0;
    logic        last_src = 1'b0;
    logic [11:0] last_off = '0;
    logic [11:0] req_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        bit          e_req, e_upd, e_start;
        logic [11:0] e_addr, e_off;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                e_req   = (m_mode == M_FETCH);
                e_addr  = e_req ? pc_in : 12'h000;
                e_upd   = (m_mode == M_BUSY) && m_upd;
                e_start = (m_mode == M_BUSY) && !m_upd && (m_age == 2);
                e_off   = e_upd ? m_ir[11:0] : 12'h000;
                chk("imem_req",   32'(imem_req),   32'(e_req));
                chk("imem_addr",  32'(imem_addr),  32'(e_addr));
                chk("exec_start", 32'(exec_start), 32'(e_start));
                chk("PC_Write",   32'(PC_Write),   32'(e_upd));
                chk("PC_Src",     32'(PC_Src),     32'(e_upd && m_take));
                chk("PC_offset",  32'(PC_offset),  32'(e_off));
                chk("instr_out",  32'(instr_out),  32'(m_ir));
                chk("retired",    32'(retired),    32'(m_ret));
                chk("halted",     32'(halted),     32'(m_mode == M_HALT));
                chk("fault",      32'(fault),      32'(m_mode == M_ERROR));
                if (PC_Write) begin
                    pcw_cnt++;
                    last_src = PC_Src;
                    last_off = PC_offset;
                    upd_cyc  = cyc;
                end
                if (exec_start) es_cnt++;
                if (imem_req) begin
                    req_cnt++;
                    req_addr = imem_addr;
                end
                if (imem_req && imem_ack) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_one(input logic [15:0] word, input int settle);
        imem_rdata = word;
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(settle);
    endtask

    task automatic wait_start(input string nm);
        int k = 0;
        while (!exec_start && k < 20) begin
            tick(1);
            k++;
        end
        chk(nm, 32'(exec_start), 32'd1);
    endtask

    task automatic wait_pcw(input string nm);
        int k = 0;
        while (!PC_Write && k < 20) begin
            tick(1);
            k++;
        end
        chk(nm, 32'(PC_Write), 32'd1);
    endtask

    task automatic stimulus();
        int b_pcw, b_es, b_req, b_ack;
        tick(3);
        reset = 1'b0;
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_instr",   32'(instr_out), 32'h0);
        chk("rst_req",     32'(imem_req), 32'h0);
        tick(2);

        // plain execute instruction, exec_done two cycles after exec_start
        pc_in = 12'h010; done_delay = 8'd2;
        b_pcw = pcw_cnt; b_es = es_cnt;
        run_one(16'h1234, 12);
        chk("s1_addr",    32'(req_addr), 32'h010);
        chk("s1_pcw",     32'(pcw_cnt - b_pcw), 32'd1);
        chk("s1_start",   32'(es_cnt - b_es), 32'd1);
        chk("s1_src",     32'(last_src), 32'd0);
        chk("s1_retired", 32'(retired), 32'd1);
        chk("s1_ir",      32'(instr_out), 32'h1234);
        chk("s1_latency", 32'(upd_cyc - ack_cyc), 32'd5);

        // unconditional branch
        pc_in = 12'h011;
        b_pcw = pcw_cnt; b_es = es_cnt;
        run_one(16'hD005, 8);
        chk("s2_start",   32'(es_cnt - b_es), 32'd0);
        chk("s2_pcw",     32'(pcw_cnt - b_pcw), 32'd1);
        chk("s2_src",     32'(last_src), 32'd1);
        chk("s2_off",     32'(last_off), 32'h005);
        chk("s2_latency", 32'(upd_cyc - ack_cyc), 32'd2);
        chk("s2_retired", 32'(retired), 32'd2);

        // conditional branch, not taken then taken
        zero_flag = 1'b0;
        run_one(16'hC003, 8);
        chk("s3a_src", 32'(last_src), 32'd0);
        chk("s3a_off", 32'(last_off), 32'h003);
        zero_flag = 1'b1;
        run_one(16'hC003, 8);
        chk("s3b_src", 32'(last_src), 32'd1);
        chk("s3b_off", 32'(last_off), 32'h003);
        chk("s3_retired", 32'(retired), 32'd4);
        zero_flag = 1'b0;

        // run dropped while waiting for exec_done
        done_delay = 8'd4;
        b_pcw = pcw_cnt; b_ack = ack_cnt;
        imem_rdata = 16'h2111;
        run = 1'b1;
        wait_start("s5_start");
        tick(1);
        run = 1'b0;
        tick(10);
        chk("s5_pcw",     32'(pcw_cnt - b_pcw), 32'd1);
        chk("s5_fetches", 32'(ack_cnt - b_ack), 32'd1);
        chk("s5_idle",    32'(imem_req), 32'd0);
        chk("s5_retired", 32'(retired), 32'd5);

        // reset while waiting for exec_done
        done_delay = 8'd250;
        b_pcw = pcw_cnt;
        run = 1'b1;
        wait_start("s6_start");
        run = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("s6_pcw",     32'(pcw_cnt - b_pcw), 32'd0);
        chk("s6_retired", 32'(retired), 32'd0);
        chk("s6_ir",      32'(instr_out), 32'h0);

        // reset in UPDATE with run still high
        b_pcw = pcw_cnt;
        imem_rdata = 16'hD00A;
        run = 1'b1;
        wait_pcw("s7_upd");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        run = 1'b0;
        chk("s7_pcw_after", 32'(PC_Write), 32'd0);
        chk("s7_req_after", 32'(imem_req), 32'd0);
        chk("s7_retired",   32'(retired), 32'd0);
        tick(3);
        chk("s7_pcw",       32'(pcw_cnt - b_pcw), 32'd1);

        // halt after one retired instruction
        done_delay = 8'd2;
        run_one(16'h1234, 10);
        imem_rdata = 16'hF000;
        run = 1'b1;
        tick(4);
        b_req = req_cnt;
        tick(20);
        chk("s8_halted",  32'(halted), 32'd1);
        chk("s8_reqs",    32'(req_cnt - b_req), 32'd0);
        chk("s8_retired", 32'(retired), 32'd1);
        run = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("s8_cleared", 32'(halted), 32'd0);

        // memory never acknowledges
        ack_en = 1'b0;
        b_req = req_cnt;
        run = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        tick(40);
        chk("s9_fault",  32'(fault), 32'd1);
        chk("s9_cycles", 32'(req_cnt - b_req), 32'd16);
        chk("s9_req",    32'(imem_req), 32'd0);
`else
        tick(100);
        chk("s9_fault",  32'(fault), 32'd0);
        chk("s9_req",    32'(imem_req), 32'd1);
        chk("s9_cycles", 32'(req_cnt - b_req), 32'd99);
`endif
        run = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        ack_en = 1'b1;
        tick(1);
        chk("s9_cleared", 32'(fault), 32'd0);
    endtask

    initial begin
        fork
            compare_loop();
            stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
